// File: rtl/data_mem_unit_pkg.sv
// Shared types for the MEM-stage data memory.
//   mem_size_e : access width encoding used on the request bus
//   size_bytes : number of bytes an access of a given width touches
package data_mem_unit_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  // The reserved encoding moves no data, so it reports zero bytes.
  function automatic logic [2:0] size_bytes(mem_size_e s);
    case (s)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      MEM_W:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus between the pipeline MEM stage and the data memory.
//   master : pipeline side (drives requests, observes responses)
//   slave  : memory side  (accepts requests, drives responses)
// Signals: req_valid/req_ready handshake, req_write, req_size, req_unsigned,
//   address, writeData; resp_valid pulse with memData, misaligned,
//   out_of_range; busy while the array is being cleared.
interface data_mem_unit_if;
  import data_mem_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  mem_size_e   req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        resp_valid;
  logic [31:0] memData;
  logic        misaligned;
  logic        out_of_range;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, writeData,
    input  req_ready, resp_valid, memData, misaligned, out_of_range, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, writeData,
    output req_ready, resp_valid, memData, misaligned, out_of_range, busy
  );

endinterface

// File: rtl/data_mem_unit_load_align.sv
// Load result formatter: takes the four bytes starting at the load address
// (byte lane 0 = lowest address) and produces the 32-bit register value.
//   raw_i      in  32  bytes addr+3..addr+0
//   size_i     in  2   access width
//   unsigned_i in  1   1 zero-extend, 0 sign-extend
//   data_o     out 32  extended result (0 for the reserved width)
module data_mem_unit_load_align
  import data_mem_unit_pkg::*;
(
  input  logic [31:0] raw_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~unsigned_i & raw_i[7];
  assign sign_h = ~unsigned_i & raw_i[15];

  always_comb begin
    data_o = '0;
    case (size_i)
      MEM_B:   data_o = {{24{sign_b}}, raw_i[7:0]};
      MEM_H:   data_o = {{16{sign_h}}, raw_i[15:0]};
      MEM_W:   data_o = raw_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressable data memory for the MEM stage with RV32 byte/half/word
// loads and stores, alignment/range fault reporting, configurable load wait
// states and an optional zeroing pass after reset.
//   clk    in  1  clock, all state on the rising edge
//   reset  in  1  asynchronous, active-low
//   bus    slave modport of data_mem_unit_if (request handshake, response
//          pulse with memData/misaligned/out_of_range, busy)
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH_BYTES    = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_unit_if.slave bus
);

  if ((DEPTH_BYTES < 8) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0)) begin : g_bad_depth
    $error("data_mem_unit: DEPTH_BYTES must be a power of 2 and at least 8");
  end
  if ((READ_LATENCY < 0) || (READ_LATENCY > 3)) begin : g_bad_latency
    $error("data_mem_unit: READ_LATENCY must be in 0..3");
  end

  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH_BYTES);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_e;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [7:0] mem [DEPTH_BYTES];

  state_e          state_q, state_d;
  logic [AW-1:0]   clear_ptr_q, clear_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            ready_q, resp_valid_q, busy_q;
  logic            mis_q, oor_q;
  logic [31:0]     mem_data_q;
  logic            write_q, uns_q;
  mem_size_e       size_q;
  logic [AW-1:0]   addr_q;

  logic            accept;
  logic [2:0]      req_nb;
  logic            req_mis, req_oor, req_fault, store_en;
  logic            rd_from_req, rd_uns, resp_write, resp_mis, resp_oor;
  mem_size_e       rd_size;
  logic [AW-1:0]   rd_addr;
  logic [31:0]     rd_raw, rd_data;

  // Request decode: faults use the full 32-bit address so high addresses
  // never alias back into the array.
  assign accept    = bus.req_valid && ready_q && (state_q == S_IDLE);
  assign req_nb    = size_bytes(bus.req_size);
  assign req_mis   = ((bus.req_size == MEM_H) && bus.address[0]) ||
                     ((bus.req_size == MEM_W) && (bus.address[1:0] != 2'b00)) ||
                     (bus.req_size == MEM_RSVD);
  assign req_oor   = ({1'b0, bus.address} + 33'(req_nb)) > DEPTH_EXT;
  assign req_fault = req_mis || req_oor;
  assign store_en  = accept && bus.req_write && !req_fault;

  // With no wait states the response is formed on the accept edge, so the
  // read path takes the live request instead of the latched copy.
  assign rd_from_req = (state_q == S_IDLE);
  assign rd_addr     = rd_from_req ? bus.address[AW-1:0] : addr_q;
  assign rd_size     = rd_from_req ? bus.req_size : size_q;
  assign rd_uns      = rd_from_req ? bus.req_unsigned : uns_q;
  assign resp_write  = rd_from_req ? bus.req_write : write_q;
  // Requests reaching WAIT were fault-free when accepted.
  assign resp_mis    = rd_from_req && req_mis;
  assign resp_oor    = rd_from_req && req_oor;

  assign rd_raw = {mem[rd_addr + AW'(3)], mem[rd_addr + AW'(2)],
                   mem[rd_addr + AW'(1)], mem[rd_addr]};

  data_mem_unit_load_align u_align (
    .raw_i      (rd_raw),
    .size_i     (rd_size),
    .unsigned_i (rd_uns),
    .data_o     (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_CLEAR: begin
        clear_ptr_d = clear_ptr_q + AW'(4);
        if (clear_ptr_q == AW'(DEPTH_BYTES - 4)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          if ((READ_LATENCY == 0) || bus.req_write || req_fault) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 2'd0;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (int'(cnt_q) == READ_LATENCY - 1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; all outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RST_STATE;
      clear_ptr_q  <= '0;
      cnt_q        <= 2'd0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= (CLEAR_ON_RESET != 0);
      mis_q        <= 1'b0;
      oor_q        <= 1'b0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      cnt_q        <= cnt_d;
      ready_q      <= (state_d == S_IDLE);
      resp_valid_q <= (state_d == S_RESP);
      busy_q       <= (state_d == S_CLEAR);
      if (state_d == S_RESP) begin
        mis_q <= resp_mis;
        oor_q <= resp_oor;
        if (!resp_write) mem_data_q <= (resp_mis || resp_oor) ? 32'h0 : rd_data;
      end
    end
  end

  // Latched request fields, only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.req_write;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.address[AW-1:0];
    end
  end

  // Array: zeroing pass or little-endian store of the size-covered bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == S_CLEAR) begin
        for (int k = 0; k < 4; k++) mem[clear_ptr_q + AW'(k)] <= 8'h00;
      end else if (store_en) begin
        for (int k = 0; k < 4; k++) begin
          if (k < int'(req_nb)) mem[bus.address[AW-1:0] + AW'(k)] <= bus.writeData[8*k +: 8];
        end
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.memData      = mem_data_q;
  assign bus.misaligned   = mis_q;
  assign bus.out_of_range = oor_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam int DA = 1024, RLA = 3;
  localparam int DB = 64,   RLB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  data_mem_unit_if ifa();
  data_mem_unit_if ifb();

  data_mem_unit #(.DEPTH_BYTES(DA), .READ_LATENCY(RLA), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave));
  data_mem_unit #(.DEPTH_BYTES(DB), .READ_LATENCY(RLB), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave));

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model of DUT A ----------------
  logic [7:0] mdl [DA];

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] data;
    bit          mis;
    bit          oor;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit          chk_en = 0;
  logic [31:0] hold_data = 0;
  bit          hold_known = 0, hold_mis = 0, hold_oor = 0;
  logic [31:0] last_data = 0;
  bit          last_mis = 0, last_oor = 0;
  int          last_resp_cyc = 0, last_acc_cyc = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] ad);
    return (sz == 2'd1 && (ad % 2) != 0) || (sz == 2'd2 && (ad % 4) != 0) || (sz == 2'd3);
  endfunction

  function automatic bit f_oor(input logic [31:0] ad, input logic [1:0] sz, input int depth);
    longint unsigned a;
    a = ad;
    return (a + longint'(nbytes(sz))) > longint'(depth);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] ad, input logic [1:0] sz, input bit un);
    int unsigned v;
    int a;
    a = int'(ad);
    v = 0;
    for (int i = 0; i < nbytes(sz); i++) v = v + (int'(mdl[a + i]) << (8 * i));
    if (!un && sz == 2'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
    if (!un && sz == 2'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check1("req_ready", ifa.req_ready, q.size() == 0);
      check1("busy_idle", ifa.busy, 1'b0);
      if (ifa.resp_valid) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check32("resp_cycle", cyc, e.cyc);
          if (!e.wr) check32("memData", ifa.memData, e.data);
          check1("misaligned", ifa.misaligned, e.mis);
          check1("out_of_range", ifa.out_of_range, e.oor);
          hold_mis = e.mis;
          hold_oor = e.oor;
          hold_known = !e.wr;
          hold_data = e.data;
        end
        last_data = ifa.memData;
        last_mis = ifa.misaligned;
        last_oor = ifa.out_of_range;
        last_resp_cyc = cyc;
      end else begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          checks++; errs++;
          $display("FAIL missing_resp: got resp_valid=0 expected 1 (cycle %0d)", cyc);
          void'(q.pop_front());
        end
        check1("misaligned_hold", ifa.misaligned, hold_mis);
        check1("out_of_range_hold", ifa.out_of_range, hold_oor);
        if (hold_known) check32("memData_hold", ifa.memData, hold_data);
      end
    end
  end

  task automatic issue_a(input bit wr, input logic [1:0] sz, input bit un,
                         input logic [31:0] ad, input logic [31:0] wd);
    exp_t e2;
    bit ok, mi, oo;
    ifa.req_write = wr;
    ifa.req_size = mem_size_e'(sz);
    ifa.req_unsigned = un;
    ifa.address = ad;
    ifa.writeData = wd;
    ifa.req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      ok = ifa.req_ready;
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
    end else begin
      mi = f_mis(sz, ad);
      oo = f_oor(ad, sz, DA);
      e2.cyc = cyc + ((wr || mi || oo) ? 1 : 1 + RLA);
      e2.wr = wr;
      e2.mis = mi;
      e2.oor = oo;
      e2.data = (mi || oo) ? 32'h0 : model_load(ad, sz, un);
      if (wr && !mi && !oo)
        for (int i = 0; i < nbytes(sz); i++) mdl[int'(ad) + i] = wd[8*i +: 8];
      q.push_back(e2);
      last_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      checks++; errs++;
      $display("FAIL resp_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_lit(input string nm, input bit wr, input logic [1:0] sz, input bit un,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] xd, input bit xm, input bit xo);
    issue_a(wr, sz, un, ad, wd);
    wait_idle();
    if (!wr) check32({nm, "_data"}, last_data, xd);
    check1({nm, "_mis"}, last_mis, xm);
    check1({nm, "_oor"}, last_oor, xo);
  endtask

  task automatic measure_clear();
    int n;
    bit done, rdy_bad, resp_bad;
    n = 0; done = 0; rdy_bad = 0; resp_bad = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (ifa.resp_valid) resp_bad = 1;
      if (ifa.busy) begin
        n++;
        if (ifa.req_ready) rdy_bad = 1;
      end else begin
        done = 1;
      end
    end
    check32("busy_cycles", n, 256);
    check1("ready_low_during_clear", rdy_bad, 1'b0);
    check1("no_resp_during_clear", resp_bad, 1'b0);
    check1("ready_after_clear", ifa.req_ready, 1'b1);
    for (int i = 0; i < DA; i++) mdl[i] = 8'h00;
    hold_data = 0; hold_known = 1; hold_mis = 0; hold_oor = 0;
    @(posedge clk); #1;
  endtask

  task automatic issue_b(input bit wr, input logic [1:0] sz, input bit un,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] d, output bit mi, output bit oo, output int lat);
    bit ok, got;
    int acc;
    d = 0; mi = 0; oo = 0; lat = -1; acc = 0;
    ifb.req_write = wr;
    ifb.req_size = mem_size_e'(sz);
    ifb.req_unsigned = un;
    ifb.address = ad;
    ifb.writeData = wd;
    ifb.req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      ok = ifb.req_ready;
      acc = cyc;
    end
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && ok && !got; i++) begin
      @(negedge clk);
      if (ifb.resp_valid) begin
        got = 1; d = ifb.memData; mi = ifb.misaligned; oo = ifb.out_of_range; lat = cyc - acc;
      end
    end
    if (!ok || !got) begin
      checks++; errs++;
      $display("FAIL b_handshake_timeout: got accepted=%0b responded=%0b expected 1/1", ok, got);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ad, wd, m, bd;
    logic [1:0] sz;
    bit wr, un, bm, bo;
    int r, bl;

    ifa.req_valid = 0; ifa.req_write = 0; ifa.req_size = MEM_B; ifa.req_unsigned = 0;
    ifa.address = 0; ifa.writeData = 0;
    ifb.req_valid = 0; ifb.req_write = 0; ifb.req_size = MEM_B; ifb.req_unsigned = 0;
    ifb.address = 0; ifb.writeData = 0;

    #2 rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_resp_valid", ifa.resp_valid, 1'b0);
    check32("rst_memData", ifa.memData, 32'h0);
    check1("rst_misaligned", ifa.misaligned, 1'b0);
    check1("rst_out_of_range", ifa.out_of_range, 1'b0);
    check1("rst_busy", ifa.busy, 1'b1);
    check1("rst_req_ready", ifa.req_ready, 1'b0);
    check1("b_rst_busy", ifb.busy, 1'b0);
    check1("b_rst_req_ready", ifb.req_ready, 1'b0);

    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    measure_clear();
    chk_en = 1;

    do_lit("lw_clr0",   0, 2'd2, 0, 32'h0,   0, 32'h0, 0, 0);
    do_lit("lw_clr1f0", 0, 2'd2, 0, 32'h1F0, 0, 32'h0, 0, 0);
    do_lit("lw_clr3fc", 0, 2'd2, 0, 32'h3FC, 0, 32'h0, 0, 0);
    check32("load_latency", last_resp_cyc - last_acc_cyc, 4);

    do_lit("sw_10",   1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    check32("store_latency", last_resp_cyc - last_acc_cyc, 1);
    do_lit("lb_10",   0, 2'd0, 0, 32'h10, 0, 32'hFFFF_FFEF, 0, 0);
    do_lit("lbu_13",  0, 2'd0, 1, 32'h13, 0, 32'h0000_00DE, 0, 0);
    do_lit("lh_12",   0, 2'd1, 0, 32'h12, 0, 32'hFFFF_DEAD, 0, 0);
    do_lit("lhu_10",  0, 2'd1, 1, 32'h10, 0, 32'h0000_BEEF, 0, 0);
    do_lit("sb_11",   1, 2'd0, 0, 32'h11, 32'h0000_0055, 0, 0, 0);
    do_lit("lw_10",   0, 2'd2, 0, 32'h10, 0, 32'hDEAD_55EF, 0, 0);
    do_lit("lh_21",   0, 2'd1, 0, 32'h21, 0, 32'h0, 1, 0);
    check32("fault_load_latency", last_resp_cyc - last_acc_cyc, 1);
    do_lit("sw_3fe",  1, 2'd2, 0, 32'h3FE, 32'h1234_5678, 0, 1, 1);
    do_lit("lw_3fc",  0, 2'd2, 0, 32'h3FC, 0, 32'h0, 0, 0);
    do_lit("sb_400",  1, 2'd0, 0, 32'h400, 32'hAA, 0, 0, 1);
    do_lit("lw_ffff", 0, 2'd2, 0, 32'hFFFF_FFFF, 0, 32'h0, 1, 1);
    do_lit("lw_fffc", 0, 2'd2, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 1);

    // back-to-back randomized traffic, req_valid kept high between requests
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      wr = $urandom_range(0, 1);
      un = $urandom_range(0, 1);
      sz = 2'($urandom_range(0, 2));
      wd = $urandom;
      if (r < 4)       ad = $urandom_range(0, 63);
      else if (r < 7)  ad = $urandom_range(0, DA - 1);
      else if (r == 7) ad = DA - 8 + $urandom_range(0, 11);
      else if (r == 8) ad = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else begin
        sz = 2'd3;
        ad = $urandom_range(0, DA - 4);
      end
      if (r <= 7 && $urandom_range(0, 3) != 0) begin
        m = 32'(nbytes(sz) - 1);
        ad = ad & ~m;
      end
      issue_a(wr, sz, un, ad, wd);
    end
    wait_idle();

    // reset while a load sits in WAIT
    do_lit("sw_pre", 1, 2'd2, 0, 32'h10, 32'hCAFE_F00D, 0, 0, 0);
    do_lit("lw_pre", 0, 2'd2, 0, 32'h10, 0, 32'hCAFE_F00D, 0, 0);
    do_lit("sh_3ff", 1, 2'd1, 0, 32'h3FF, 32'h1111, 0, 1, 1);
    issue_a(0, 2'd2, 0, 32'h10, 0);
    chk_en = 0;
    q.delete();
    #1 rst_a = 1'b0;
    #1;
    check1("wrst_resp_valid", ifa.resp_valid, 1'b0);
    check32("wrst_memData", ifa.memData, 32'h0);
    check1("wrst_misaligned", ifa.misaligned, 1'b0);
    check1("wrst_out_of_range", ifa.out_of_range, 1'b0);
    check1("wrst_busy", ifa.busy, 1'b1);
    check1("wrst_req_ready", ifa.req_ready, 1'b0);
    bm = 0;
    repeat (4) begin
      @(negedge clk);
      if (ifa.resp_valid) bm = 1;
    end
    check1("no_resp_in_reset", bm, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    measure_clear();
    chk_en = 1;
    do_lit("lw_after_rst", 0, 2'd2, 0, 32'h10, 0, 32'h0, 0, 0);
    do_lit("lw_after_rst_3fc", 0, 2'd2, 0, 32'h3FC, 0, 32'h0, 0, 0);
    chk_en = 0;

    // DUT B: no wait states, no clearing pass
    issue_b(1, 2'd2, 0, 32'h8, 32'h1234_5678, bd, bm, bo, bl);
    check32("b_sw_latency", bl, 1);
    check1("b_sw_mis", bm, 1'b0);
    check1("b_sw_oor", bo, 1'b0);
    issue_b(0, 2'd2, 0, 32'h8, 0, bd, bm, bo, bl);
    check32("b_lw_data", bd, 32'h1234_5678);
    check32("b_lw_latency", bl, 1);
    issue_b(0, 2'd1, 0, 32'h3F, 0, bd, bm, bo, bl);
    check32("b_lh_3f_data", bd, 32'h0);
    check1("b_lh_3f_mis", bm, 1'b1);
    check1("b_lh_3f_oor", bo, 1'b1);
    issue_b(1, 2'd0, 0, 32'h3F, 32'h0000_00A5, bd, bm, bo, bl);
    check1("b_sb_3f_oor", bo, 1'b0);
    issue_b(0, 2'd0, 0, 32'h3F, 0, bd, bm, bo, bl);
    check32("b_lb_3f_data", bd, 32'hFFFF_FFA5);
    rst_b = 1'b0;
    #1;
    check32("b_rst_memData", ifb.memData, 32'h0);
    check1("b_rst2_busy", ifb.busy, 1'b0);
    check1("b_rst2_ready", ifb.req_ready, 1'b0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    issue_b(0, 2'd2, 0, 32'h8, 0, bd, bm, bo, bl);
    check32("b_survive_lw", bd, 32'h1234_5678);
    issue_b(0, 2'd0, 1, 32'h3F, 0, bd, bm, bo, bl);
    check32("b_survive_lbu", bd, 32'h0000_00A5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
